// File: rtl/fetch_if_id.sv
// Instruction fetch stage with IF/ID pipeline register, memory-wait handling and branch redirect.
// Optional misaligned-PC trap is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_if_id #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pause_pc,
    input  logic        wrt_IF_ID,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        halt_ID,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_stall,
    input  logic        imem_done,
    output logic [15:0] instr_IF_ID,
    output logic [15:0] pc_inc_IF_ID,
    output logic        valid_IF_ID,
    output logic        fetch_stall,
    output logic        err
);

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        HALT
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] pc_inc_q;
    logic        valid_q;
    logic        discard_q;
    logic        err_q;
    logic [15:0] pc_plus2;
    logic        misaligned;
    logic        unused_stall;

    assign pc_plus2 = pc_q + 16'd2;
    // imem_done alone marks data valid; the busy flag is informational only
    assign unused_stall = imem_stall;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = pc_q[0] && (state_q != HALT);
`else
    assign misaligned = 1'b0;
`endif

    assign imem_addr    = pc_q;
    assign imem_rd      = (state_q != HALT) && !misaligned;
    assign fetch_stall  = (state_q == WAIT) || ((state_q == RUN) && !imem_done);
    assign instr_IF_ID  = instr_q;
    assign pc_inc_IF_ID = pc_inc_q;
    assign valid_IF_ID  = valid_q;
    assign err          = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            pc_inc_q  <= 16'h0000;
            valid_q   <= 1'b0;
            discard_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (state_q == HALT) begin
            valid_q <= 1'b0;
        end else if (br_taken) begin
            pc_q    <= br_target;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            state_q <= RUN;
            // A response still in flight belongs to the old path and must be dropped
            discard_q <= ((state_q == WAIT) || discard_q) && !imem_done;
        end else if (misaligned) begin
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            state_q <= HALT;
        end else begin
            if (imem_done && discard_q) begin
                discard_q <= 1'b0;
                state_q   <= RUN;
            end else if (imem_done) begin
                if (!pause_pc) begin
                    pc_q <= pc_plus2;
                end
                if (wrt_IF_ID) begin
                    instr_q  <= imem_data;
                    pc_inc_q <= pc_plus2;
                    valid_q  <= 1'b1;
                end
                state_q <= RUN;
            end else begin
                // Nothing delivered: hand decode a bubble instead of replaying the old word
                if (wrt_IF_ID) begin
                    instr_q <= NOP_INSTR;
                    valid_q <= 1'b0;
                end
                state_q <= WAIT;
            end
            if (halt_ID) begin
                state_q <= HALT;
            end
        end
    end

endmodule

// File: tb/tb_fetch_if_id.sv
// Self-checking bench for fetch_if_id: vector table plus hand-written reset, wrap and redirect sequences.
module tb_fetch_if_id;

    typedef struct {
        logic        pause;
        logic        wrt;
        logic        br;
        logic [15:0] tgt;
        logic        halt;
        logic [15:0] data;
        logic        done;
        logic [15:0] eAddr;
        logic        eRd;
        logic        eStall;
        logic [15:0] eInstr;
        logic [15:0] eInc;
        logic        eValid;
        logic        chkInc;
        logic        eErr;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        pause_pc;
    logic        wrt_IF_ID;
    logic        br_taken;
    logic [15:0] br_target;
    logic        halt_ID;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_stall;
    logic        imem_done;
    logic [15:0] instr_IF_ID;
    logic [15:0] pc_inc_IF_ID;
    logic        valid_IF_ID;
    logic        fetch_stall;
    logic        err;

    int   checks;
    int   failures;
    vec_t vecs[$];
    vec_t sbQ[$];

    fetch_if_id dut (
        .clk(clk),
        .rst_n(rst_n),
        .pause_pc(pause_pc),
        .wrt_IF_ID(wrt_IF_ID),
        .br_taken(br_taken),
        .br_target(br_target),
        .halt_ID(halt_ID),
        .imem_addr(imem_addr),
        .imem_rd(imem_rd),
        .imem_data(imem_data),
        .imem_stall(imem_stall),
        .imem_done(imem_done),
        .instr_IF_ID(instr_IF_ID),
        .pc_inc_IF_ID(pc_inc_IF_ID),
        .valid_IF_ID(valid_IF_ID),
        .fetch_stall(fetch_stall),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic pause, input logic wrt, input logic br,
                                input logic [15:0] tgt, input logic halt,
                                input logic [15:0] data, input logic done,
                                input logic [15:0] eAddr, input logic eRd, input logic eStall,
                                input logic [15:0] eInstr, input logic [15:0] eInc,
                                input logic eValid, input logic chkInc, input logic eErr);
        vec_t v;
        v.pause = pause;   v.wrt = wrt;       v.br = br;         v.tgt = tgt;
        v.halt = halt;     v.data = data;     v.done = done;
        v.eAddr = eAddr;   v.eRd = eRd;       v.eStall = eStall;
        v.eInstr = eInstr; v.eInc = eInc;     v.eValid = eValid;
        v.chkInc = chkInc; v.eErr = eErr;
        return v;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, compare request-side outputs before the edge, IF/ID after it
    task automatic applyStimulus(input vec_t v, input string tag);
        vec_t e;
        pause_pc  = v.pause;
        wrt_IF_ID = v.wrt;
        br_taken  = v.br;
        br_target = v.tgt;
        halt_ID   = v.halt;
        imem_data = v.data;
        imem_done = v.done;
        imem_stall = !v.done;
        sbQ.push_back(v);
        @(negedge clk);
        check16({tag, ".imem_addr"}, imem_addr, v.eAddr);
        check16({tag, ".imem_rd"}, {15'd0, imem_rd}, {15'd0, v.eRd});
        check16({tag, ".fetch_stall"}, {15'd0, fetch_stall}, {15'd0, v.eStall});
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s.scoreboard actual=empty expected=entry", tag);
            return;
        end
        e = sbQ.pop_front();
        check16({tag, ".instr"}, instr_IF_ID, e.eInstr);
        if (e.chkInc) check16({tag, ".pc_inc"}, pc_inc_IF_ID, e.eInc);
        check16({tag, ".valid"}, {15'd0, valid_IF_ID}, {15'd0, e.eValid});
        check16({tag, ".err"}, {15'd0, err}, {15'd0, e.eErr});
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        imem_done = 1'b1;
        br_taken = 1'b0;
        halt_ID = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check16({tag, ".pc"}, imem_addr, 16'h0000);
        check16({tag, ".instr"}, instr_IF_ID, 16'h0800);
        check16({tag, ".pc_inc"}, pc_inc_IF_ID, 16'h0000);
        check16({tag, ".valid"}, {15'd0, valid_IF_ID}, 16'h0000);
        check16({tag, ".err"}, {15'd0, err}, 16'h0000);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        pause_pc = 1'b0;
        wrt_IF_ID = 1'b1;
        br_taken = 1'b0;
        br_target = 16'h0000;
        halt_ID = 1'b0;
        imem_data = 16'h0000;
        imem_done = 1'b1;
        imem_stall = 1'b0;
        @(posedge clk);
        doReset("reset0");

        //               pause wrt br  tgt    halt data     done addr     rd stall instr    inc      vld chk err
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'hC001, 1, 16'h0000, 1, 0, 16'hC001, 16'h0002, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'hC002, 1, 16'h0002, 1, 0, 16'hC002, 16'h0004, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'hC003, 1, 16'h0004, 1, 0, 16'hC002, 16'h0004, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'hC003, 1, 16'h0004, 1, 0, 16'hC002, 16'h0004, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'hC003, 1, 16'h0004, 1, 0, 16'hC003, 16'h0006, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'hBAD0, 0, 16'h0006, 1, 1, 16'h0800, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'hBAD1, 0, 16'h0006, 1, 1, 16'h0800, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'hBAD2, 0, 16'h0006, 1, 1, 16'h0800, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'hC004, 1, 16'h0006, 1, 1, 16'hC004, 16'h0008, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'hBAD3, 0, 16'h0008, 1, 1, 16'h0800, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 16'h0040, 0, 16'hBAD4, 0, 16'h0008, 1, 1, 16'h0800, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'hDEAD, 1, 16'h0040, 1, 0, 16'h0800, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'hC040, 1, 16'h0040, 1, 0, 16'hC040, 16'h0042, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 16'hC042, 1, 16'h0042, 1, 0, 16'hC042, 16'h0044, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'hC044, 1, 16'h0044, 0, 0, 16'hC042, 16'h0044, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'hC046, 1, 16'h0044, 0, 0, 16'hC042, 16'h0044, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 16'h0080, 0, 16'hC048, 1, 16'h0044, 0, 0, 16'hC042, 16'h0044, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        doReset("resetFromHalt");
        applyStimulus(mk(0, 1, 0, 16'h0000, 0, 16'hC0A0, 1, 16'h0000, 1, 0, 16'hC0A0, 16'h0002, 1, 1, 0), "afterHalt");

        applyStimulus(mk(0, 1, 0, 16'h0000, 0, 16'hBAD5, 0, 16'h0002, 1, 1, 16'h0800, 16'h0000, 0, 0, 0), "enterWait");
        doReset("resetInWait");
        applyStimulus(mk(0, 1, 0, 16'h0000, 0, 16'hC0BB, 1, 16'h0000, 1, 0, 16'hC0BB, 16'h0002, 1, 1, 0), "noDiscardAfterReset");

        applyStimulus(mk(0, 1, 1, 16'h0100, 1, 16'h1111, 1, 16'h0002, 1, 0, 16'h0800, 16'h0000, 0, 0, 0), "brBeatsHalt");
        applyStimulus(mk(0, 1, 0, 16'h0000, 0, 16'hC100, 1, 16'h0100, 1, 0, 16'hC100, 16'h0102, 1, 1, 0), "afterBrHalt");

        applyStimulus(mk(1, 1, 0, 16'h0000, 0, 16'hC200, 1, 16'h0102, 1, 0, 16'hC200, 16'h0104, 1, 1, 0), "pauseWrite");
        applyStimulus(mk(0, 1, 0, 16'h0000, 0, 16'hC201, 1, 16'h0102, 1, 0, 16'hC201, 16'h0104, 1, 1, 0), "pcHeld");

        applyStimulus(mk(0, 0, 0, 16'h0000, 0, 16'hC2FF, 1, 16'h0104, 1, 0, 16'hC201, 16'h0104, 1, 1, 0), "ifidHold");
        applyStimulus(mk(0, 1, 0, 16'h0000, 0, 16'hC202, 1, 16'h0106, 1, 0, 16'hC202, 16'h0108, 1, 1, 0), "pcAdvanced");

        applyStimulus(mk(0, 1, 1, 16'hFFFE, 0, 16'hBAD6, 0, 16'h0108, 1, 1, 16'h0800, 16'h0000, 0, 0, 0), "brWrap");
        applyStimulus(mk(0, 1, 0, 16'h0000, 0, 16'hCFFE, 1, 16'hFFFE, 1, 0, 16'hCFFE, 16'h0000, 1, 1, 0), "wrapFetch");
        applyStimulus(mk(0, 1, 0, 16'h0000, 0, 16'hC000, 1, 16'h0000, 1, 0, 16'hC000, 16'h0002, 1, 1, 0), "afterWrap");

        applyStimulus(mk(0, 1, 1, 16'h0013, 0, 16'h2222, 1, 16'h0002, 1, 0, 16'h0800, 16'h0000, 0, 0, 0), "brOdd");
`ifdef FETCH_ALIGN_CHECK_EN
        applyStimulus(mk(0, 1, 0, 16'h0000, 0, 16'hC013, 1, 16'h0013, 0, 0, 16'h0800, 16'h0000, 0, 0, 1), "oddTrap");
        applyStimulus(mk(0, 1, 0, 16'h0000, 0, 16'hC015, 1, 16'h0013, 0, 0, 16'h0800, 16'h0000, 0, 0, 1), "oddHalted");
`else
        applyStimulus(mk(0, 1, 0, 16'h0000, 0, 16'hC013, 1, 16'h0013, 1, 0, 16'hC013, 16'h0015, 1, 1, 0), "oddIgnored");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
